mnist_argmax: RTL and testbench



---
 rtl/mnist_argmax_if.sv | 45 ++++
 rtl/mnist_argmax.sv | 144 ++++++++++++++
 tb/tb_mnist_argmax.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mnist_argmax_if.sv
// Handshake bundle between the neural-net layer, the argmax classifier and its consumer.
// The margin signal exists only when MNIST_ARGMAX_MARGIN_EN is defined.
interface mnist_argmax_if #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_CLASS = 10
);
  localparam int IDX_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

  logic                                in_valid;
  logic                                in_ready;
  logic [NUM_CLASS-1:0][BIT_WIDTH-1:0] scores;
  logic                                out_valid;
  logic                                out_ready;
  logic [IDX_W-1:0]                    class_idx;
  logic [BIT_WIDTH-1:0]                max_score;
`ifdef MNIST_ARGMAX_MARGIN_EN
  logic [BIT_WIDTH:0]                  margin;
`endif

  modport master (
    output in_valid,
    output scores,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  class_idx,
`ifdef MNIST_ARGMAX_MARGIN_EN
    input  margin,
`endif
    input  max_score
  );

  modport slave (
    input  in_valid,
    input  scores,
    input  out_ready,
    output in_ready,
    output out_valid,
    output class_idx,
`ifdef MNIST_ARGMAX_MARGIN_EN
    output margin,
`endif
    output max_score
  );
endinterface

// File: rtl/mnist_argmax.sv
// Sequential argmax over a captured vector of signed class scores, one class per cycle.
// Define MNIST_ARGMAX_MARGIN_EN to also track the runner-up and report the best-vs-second margin.
module mnist_argmax #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_CLASS = 10
) (
  input logic           clk,
  input logic           rst_n,
  mnist_argmax_if.slave bus
);
  localparam int IDX_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                          state_q, state_d;
  logic [NUM_CLASS-1:0][BIT_WIDTH-1:0] score_q, score_d;
  logic [IDX_W-1:0]                    ptr_q, ptr_d;
  logic [IDX_W-1:0]                    best_idx_q, best_idx_d;
  logic signed [BIT_WIDTH-1:0]         best_val_q, best_val_d;
  logic                                in_ready_q, in_ready_d;
  logic                                out_valid_q, out_valid_d;
  logic signed [BIT_WIDTH-1:0]         cand;
  logic                                last;

`ifdef MNIST_ARGMAX_MARGIN_EN
  localparam logic signed [BIT_WIDTH-1:0] MostNeg = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  logic signed [BIT_WIDTH-1:0] sec_val_q, sec_val_d;
  logic [BIT_WIDTH:0]          margin_q, margin_d;
`endif

  assign cand = $signed(score_q[ptr_q]);
  assign last = (ptr_q == IDX_W'(NUM_CLASS - 1));

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    ptr_d       = ptr_q;
    best_idx_d  = best_idx_q;
    best_val_d  = best_val_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef MNIST_ARGMAX_MARGIN_EN
    sec_val_d   = sec_val_q;
    margin_d    = margin_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          score_d    = bus.scores;
          best_val_d = $signed(bus.scores[0]);
          best_idx_d = '0;
          ptr_d      = IDX_W'(1);
          in_ready_d = 1'b0;
`ifdef MNIST_ARGMAX_MARGIN_EN
          sec_val_d  = MostNeg;
`endif
          if (NUM_CLASS > 1) begin
            state_d = StScan;
          end else begin
            state_d     = StDone;
            out_valid_d = 1'b1;
`ifdef MNIST_ARGMAX_MARGIN_EN
            margin_d    = '0;
`endif
          end
        end
      end
      StScan: begin
        // Strictly greater only, so ties keep the lowest index.
        if (cand > best_val_q) begin
          best_val_d = cand;
          best_idx_d = ptr_q;
`ifdef MNIST_ARGMAX_MARGIN_EN
          sec_val_d  = best_val_q;
        end else if (cand > sec_val_q) begin
          sec_val_d  = cand;
`endif
        end
        if (last) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
`ifdef MNIST_ARGMAX_MARGIN_EN
          // Uses the post-compare best/second so the last class is included.
          margin_d    = {best_val_d[BIT_WIDTH-1], best_val_d} -
                        {sec_val_d[BIT_WIDTH-1], sec_val_d};
`endif
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      score_q     <= '0;
      ptr_q       <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MNIST_ARGMAX_MARGIN_EN
      sec_val_q   <= MostNeg;
      margin_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      ptr_q       <= ptr_d;
      best_idx_q  <= best_idx_d;
      best_val_q  <= best_val_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef MNIST_ARGMAX_MARGIN_EN
      sec_val_q   <= sec_val_d;
      margin_q    <= margin_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.class_idx = best_idx_q;
  assign bus.max_score = best_val_q;
`ifdef MNIST_ARGMAX_MARGIN_EN
  assign bus.margin    = margin_q;
`endif

endmodule

// File: tb/tb_mnist_argmax.sv
// Randomized self-checking bench for mnist_argmax against a sort/max based reference model.
// Margin checks are compiled in only when MNIST_ARGMAX_MARGIN_EN is defined.
module tb_mnist_argmax;
  localparam int BIT_WIDTH = 8;
  localparam int NUM_CLASS = 10;

  typedef logic [NUM_CLASS-1:0][BIT_WIDTH-1:0] vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  longint prev_acc;

  mnist_argmax_if #(.BIT_WIDTH(BIT_WIDTH), .NUM_CLASS(NUM_CLASS)) bus ();

  mnist_argmax #(.BIT_WIDTH(BIT_WIDTH), .NUM_CLASS(NUM_CLASS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Max value, first index holding it, and gap to the second entry of the sorted multiset.
  function automatic void ref_model(input vec_t v, output int idx, output int mx, output int mg);
    int q[$];
    for (int i = 0; i < NUM_CLASS; i++) q.push_back(int'($signed(v[i])));
    mx = q[0];
    foreach (q[i]) if (q[i] > mx) mx = q[i];
    idx = 0;
    for (int i = NUM_CLASS - 1; i >= 0; i--) if (q[i] == mx) idx = i;
    q.rsort();
    mg = (NUM_CLASS > 1) ? q[0] - q[1] : 0;
  endfunction

  function automatic vec_t fill(input int val);
    vec_t v;
    for (int i = 0; i < NUM_CLASS; i++) v[i] = BIT_WIDTH'(val);
    return v;
  endfunction

  function automatic vec_t rand_vec(input bit narrow);
    vec_t v;
    for (int i = 0; i < NUM_CLASS; i++)
      v[i] = narrow ? BIT_WIDTH'($urandom_range(0, 3) - 2) : BIT_WIDTH'($urandom);
    return v;
  endfunction

  // Present one vector, follow it to its result and retire it; hold>0 applies backpressure.
  task automatic issue(input vec_t v, input int hold, input bit scramble, input bit b2b);
    int     idx, mx, mg, lat, bad;
    longint t_acc;
    ref_model(v, idx, mx, mg);
    check_eq("in_ready_idle", int'(bus.in_ready), 1);
    bus.scores    = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    t_acc = $time;
    #1;
    bus.in_valid = 1'b0;
    if (b2b) check_eq("throughput", int'((t_acc - prev_acc) / 10), NUM_CLASS + 1);
    prev_acc = t_acc;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      if (scramble) bus.scores = rand_vec(1'b0);
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", lat, NUM_CLASS - 1);
    check_eq("class_idx", int'(bus.class_idx), idx);
    check_eq("max_score", int'($signed(bus.max_score)), mx);
`ifdef MNIST_ARGMAX_MARGIN_EN
    check_eq("margin", int'(bus.margin), mg);
`endif
    if (hold > 0) begin
      bad = 0;
      bus.in_valid = 1'b1;
      bus.scores   = rand_vec(1'b0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
            int'(bus.class_idx) != idx || int'($signed(bus.max_score)) != mx) bad++;
      end
      check_eq("hold_stable", bad, 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("out_valid_drop", int'(bus.out_valid), 0);
    check_eq("in_ready_back", int'(bus.in_ready), 1);
  endtask

  initial begin
    vec_t v;
    n_checks      = 0;
    n_errors      = 0;
    prev_acc      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.scores    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_class_idx", int'(bus.class_idx), 0);
    check_eq("rst_max_score", int'(bus.max_score), 0);
`ifdef MNIST_ARGMAX_MARGIN_EN
    check_eq("rst_margin", int'(bus.margin), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic vector
    v = fill(0);
    v[0] = 8'(5);
    v[3] = 8'(90);
    v[7] = 8'(-20);
    issue(v, 0, 1'b0, 1'b0);

    // Negatives with a tie at the maximum
    v = fill(-100);
    v[4] = 8'(-3);
    v[8] = 8'(-3);
    issue(v, 0, 1'b0, 1'b0);

    // Backpressure
    issue(rand_vec(1'b0), 20, 1'b0, 1'b0);

    // Scores change while scanning
    issue(rand_vec(1'b0), 0, 1'b1, 1'b0);

    // Reset mid-scan
    bus.scores    = rand_vec(1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", int'(bus.out_valid), 0);
    check_eq("midrst_class_idx", int'(bus.class_idx), 0);
    check_eq("midrst_max_score", int'(bus.max_score), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = rand_vec(1'b0);
    for (int i = 0; i < NUM_CLASS - 1; i++) if ($signed(v[i]) == 127) v[i] = 8'(126);
    v[9] = 8'(127);
    issue(v, 0, 1'b0, 1'b0);

    // Extremes then a back-to-back burst
    v = fill(-128);
    v[1] = 8'(127);
    issue(v, 0, 1'b0, 1'b0);
    issue(v, 0, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) issue(rand_vec(n[0]), 0, 1'b0, 1'b1);

    // Random mix including ties and occasional backpressure
    for (int n = 0; n < 16; n++)
      issue(rand_vec($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0) ? 3 : 0,
            $urandom_range(0, 1) == 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
